// File: rtl/decider.sv
// decider: DPLL branching unit. Scans the variable table from a resume
// index for the first unassigned variable and offers it as a decision.
// A push into the decision stack is emitted when the offer is accepted.
// Reports sat when no unassigned variable remains in [resume_idx, num_vars).
// Optional feature macro: DECIDER_PHASE_SAVE_EN. When it is defined, a saved
// phase vector supplies the decision value. When it is undefined, the
// decision value is always 0.
module decider #(
    parameter int MAX_VARS      = 64,
    parameter int MAX_VARS_BITS = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [MAX_VARS_BITS-1:0] resume_idx,
    input  logic [MAX_VARS_BITS:0]   num_vars,
    output logic [MAX_VARS_BITS-1:0] var_rd_addr,
    input  logic                     var_rd_assigned,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [MAX_VARS_BITS-1:0] dec_idx,
    output logic                     dec_val,
    output logic                     stack_push,
    output logic                     sat,
    output logic                     busy,
    input  logic                     phase_wr_en,
    input  logic [MAX_VARS_BITS-1:0] phase_wr_idx,
    input  logic                     phase_wr_val,
    output logic [2:0]               state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        CHECK = 3'd2,
        OFFER = 3'd3,
        SAT   = 3'd4
    } state_t;

    state_t                   state;
    logic [MAX_VARS_BITS-1:0] idx;
    logic [MAX_VARS_BITS:0]   idx_next;
    logic                     phase_bit;

    // The increment is one bit wider than idx, so comparing it with
    // num_vars never wraps, even at idx = MAX_VARS-1.
    assign idx_next = {1'b0, idx} + {{MAX_VARS_BITS{1'b0}}, 1'b1};

`ifdef DECIDER_PHASE_SAVE_EN
    logic [MAX_VARS-1:0] phase;

    // Saved-phase storage. A write in the CHECK cycle is not seen by that
    // CHECK because the read returns the pre-edge value.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase <= '0;
        end else if (phase_wr_en) begin
            phase[phase_wr_idx] <= phase_wr_val;
        end
    end

    assign phase_bit = phase[idx];
`else
    logic phase_unused;
    assign phase_unused = ^{phase_wr_en, phase_wr_idx, phase_wr_val, MAX_VARS[0]};
    assign phase_bit    = 1'b0;
`endif

    // Scan FSM. abort overrides everything. Decision data is latched only
    // in CHECK, so it stays stable for the whole offer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= '0;
            dec_idx <= '0;
            dec_val <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= resume_idx;
                        state <= ({1'b0, resume_idx} < num_vars) ? READ : SAT;
                    end
                end
                READ: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (!var_rd_assigned) begin
                        dec_idx <= idx;
                        dec_val <= phase_bit;
                        state   <= OFFER;
                    end else if (idx_next == num_vars) begin
                        state <= SAT;
                    end else begin
                        idx   <= idx_next[MAX_VARS_BITS-1:0];
                        state <= READ;
                    end
                end
                OFFER: begin
                    if (dec_ready) begin
                        state <= IDLE;
                    end
                end
                SAT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake: dec_valid stays high with dec_idx/dec_val stable until a
    // cycle with dec_ready=1 (the transfer cycle, which is also the push).
    // Only abort or reset can withdraw an offer. An aborted transfer never
    // pushes.
    assign dec_valid   = (state == OFFER);
    assign stack_push  = dec_valid & dec_ready & ~abort & ~reset;
    assign sat         = (state == SAT);
    assign busy        = (state != IDLE);
    assign var_rd_addr = idx;
    assign state_dbg   = state;

endmodule
